// File: rtl/mux_pkg.sv
// ============================================================================
// Module   : mux_pkg
// Brief    : Shared constants and helpers for multiplexor_nin_reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Ceiling log2 for tools without a usable $clog2 in parameter context.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : mux_pkg

`default_nettype wire

// File: rtl/multiplexor_nin_reg_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; searches from pointer+1 upward
//            with wrap and returns a one-hot grant plus its encoded index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int SEL_W = clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] pointer,
    output logic [N_IN-1:0]  grant,
    output logic [SEL_W-1:0] index
);

    int   w_pos;
    logic w_found;

    always_comb begin
        grant   = '0;
        index   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        // The last candidate examined is the pointer itself, so it has lowest priority.
        for (int off = 1; off <= N_IN; off++) begin
            w_pos = int'(pointer) + off;
            if (w_pos >= N_IN) begin
                w_pos = w_pos - N_IN;
            end
            if (!w_found && req[w_pos[SEL_W-1:0]]) begin
                w_found                   = 1'b1;
                grant[w_pos[SEL_W-1:0]]   = 1'b1;
                index                     = w_pos[SEL_W-1:0];
            end
        end
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/multiplexor_nin_reg.sv
// ============================================================================
// Module   : multiplexor_nin_reg
// Brief    : Registered N-input valid/ready multiplexer, fixed-select or
//            round-robin. Optional macro MUX_PARITY_EN adds the Paridad output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplexor_nin_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N_IN  = 4,
    parameter int MODE  = MODE_FIXED,
    parameter int SEL_W = clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_IN*WIDTH-1:0]   Datos,
    input  logic [N_IN-1:0]         Valido_in,
    output logic [N_IN-1:0]         Listo_in,
    input  logic [SEL_W-1:0]        Sel,
    output logic [WIDTH-1:0]        Salida,
    output logic [SEL_W-1:0]        Canal,
    output logic                    Valido_out,
    input  logic                    Listo_out
`ifdef MUX_PARITY_EN
    ,
    output logic                    Paridad
`endif
);

    logic             w_load_en;
    logic             w_fire;
    logic [N_IN-1:0]  w_ready;
    logic [SEL_W-1:0] w_idx;
    logic [WIDTH-1:0] w_word;

    logic [WIDTH-1:0] r_salida;
    logic [SEL_W-1:0] r_canal;
    logic             r_valido;

    // Register can take a word when empty or being drained this cycle.
    assign w_load_en = !r_valido || Listo_out;
    assign Listo_in  = reset ? '0 : w_ready;
    assign w_fire    = |(Valido_in & Listo_in);
    assign w_word    = Datos[int'(w_idx)*WIDTH +: WIDTH];

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] r_ptr;
            logic [N_IN-1:0]  w_grant;
            logic             w_unused_sel;

            rr_arbiter #(
                .N_IN  (N_IN),
                .SEL_W (SEL_W)
            ) u_arb (
                .req     (Valido_in),
                .pointer (r_ptr),
                .grant   (w_grant),
                .index   (w_idx)
            );

            assign w_ready      = w_grant & {N_IN{w_load_en}};
            assign w_unused_sel = ^Sel;

            // Reset to the last channel so channel 0 wins first.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ptr <= SEL_W'(N_IN - 1);
                end else if (w_fire) begin
                    r_ptr <= w_idx;
                end
            end
        end else begin : g_fixed
            always_comb begin
                w_ready = '0;
                if (int'(Sel) < N_IN) begin
                    w_ready[Sel] = w_load_en;
                end
            end

            assign w_idx = Sel;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valido <= 1'b0;
            r_salida <= '0;
            r_canal  <= '0;
        end else begin
            if (w_fire) begin
                r_valido <= 1'b1;
                r_salida <= w_word;
                r_canal  <= w_idx;
            end else if (Listo_out) begin
                r_valido <= 1'b0;
            end
        end
    end

    assign Salida     = r_salida;
    assign Canal      = r_canal;
    assign Valido_out = r_valido;

`ifdef MUX_PARITY_EN
    logic r_paridad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_paridad <= 1'b0;
        end else if (w_fire) begin
            r_paridad <= ^w_word;
        end
    end

    assign Paridad = r_paridad;
`endif

endmodule : multiplexor_nin_reg

`default_nettype wire

// File: tb/tb_multiplexor_nin_reg.sv
// ============================================================================
// Module   : tb_multiplexor_nin_reg
// Brief    : Directed self-checking bench for multiplexor_nin_reg (fixed N=2,
//            round-robin N=4, fixed N=3). Parity checks under MUX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiplexor_nin_reg;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Fixed select, N_IN=2
    logic [31:0] d0;
    logic [1:0]  v0, li0;
    logic [0:0]  sel0, can0;
    logic [15:0] sal0;
    logic        vo0, lo0, par0;

    // Round-robin, N_IN=4
    logic [63:0] d1;
    logic [3:0]  v1, li1;
    logic [1:0]  sel1, can1;
    logic [15:0] sal1;
    logic        vo1, lo1, par1;

    // Fixed select, N_IN=3
    logic [47:0] d2;
    logic [2:0]  v2, li2;
    logic [1:0]  sel2, can2;
    logic [15:0] sal2;
    logic        vo2, lo2, par2;

    multiplexor_nin_reg #(.WIDTH(16), .N_IN(2), .MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .Datos(d0), .Valido_in(v0), .Listo_in(li0),
        .Sel(sel0), .Salida(sal0), .Canal(can0), .Valido_out(vo0), .Listo_out(lo0)
`ifdef MUX_PARITY_EN
        , .Paridad(par0)
`endif
    );

    multiplexor_nin_reg #(.WIDTH(16), .N_IN(4), .MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .Datos(d1), .Valido_in(v1), .Listo_in(li1),
        .Sel(sel1), .Salida(sal1), .Canal(can1), .Valido_out(vo1), .Listo_out(lo1)
`ifdef MUX_PARITY_EN
        , .Paridad(par1)
`endif
    );

    multiplexor_nin_reg #(.WIDTH(16), .N_IN(3), .MODE(0)) u_dut2 (
        .clk(clk), .reset(reset), .Datos(d2), .Valido_in(v2), .Listo_in(li2),
        .Sel(sel2), .Salida(sal2), .Canal(can2), .Valido_out(vo2), .Listo_out(lo2)
`ifdef MUX_PARITY_EN
        , .Paridad(par2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        par0 = 1'b0; par1 = 1'b0; par2 = 1'b0;
        d0 = {16'hFF00, 16'hCCCC}; v0 = 2'b11; sel0 = 1'b0; lo0 = 1'b1;
        d1 = {16'hA003, 16'hA002, 16'hA001, 16'hA000}; v1 = '0; sel1 = '0; lo1 = 1'b1;
        d2 = {16'h3333, 16'h2222, 16'h1111}; v2 = '0; sel2 = '0; lo2 = 1'b1;

        // Reset state
        repeat (2) tick;
        check("rst_valido", 32'(vo0), 32'd0);
        check("rst_salida", 32'(sal0), 32'd0);
        check("rst_canal", 32'(can0), 32'd0);
        check("rst_listo_in", 32'(li0), 32'd0);

        // Fixed select, Sel=0 then 1
        reset = 1'b0;
        #1;
        check("m0_listo_sel0", 32'(li0), 32'b01);
        tick;
        check("m0_salida_ch0", 32'(sal0), 32'hCCCC);
        check("m0_canal_ch0", 32'(can0), 32'd0);
        check("m0_valido_ch0", 32'(vo0), 32'd1);
        sel0 = 1'b1;
        #1;
        check("m0_listo_sel1", 32'(li0), 32'b10);
        tick;
        check("m0_salida_ch1", 32'(sal0), 32'hFF00);
        check("m0_canal_ch1", 32'(can0), 32'd1);

        // Backpressure
        d0[15:0] = 16'h1234; sel0 = 1'b0;
        tick;
        check("bp_load", 32'(sal0), 32'h1234);
        d0[15:0] = 16'h5678; lo0 = 1'b0;
        #1;
        check("bp_listo_stall", 32'(li0), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("bp_hold_salida", 32'(sal0), 32'h1234);
            check("bp_hold_valido", 32'(vo0), 32'd1);
            check("bp_hold_listo", 32'(li0), 32'd0);
        end
        lo0 = 1'b1;
        #1;
        check("bp_release_listo", 32'(li0), 32'b01);
        tick;
        check("bp_nobubble_salida", 32'(sal0), 32'h5678);
        check("bp_nobubble_valido", 32'(vo0), 32'd1);
        v0 = 2'b00;
        tick;
        check("drain_valido", 32'(vo0), 32'd0);
        check("drain_salida_hold", 32'(sal0), 32'h5678);
        check("drain_canal_hold", 32'(can0), 32'd0);

`ifdef MUX_PARITY_EN
        v0 = 2'b01; d0[15:0] = 16'h0001;
        tick;
        check("par_0001", 32'(par0), 32'd1);
        d0[15:0] = 16'h0003;
        tick;
        check("par_0003", 32'(par0), 32'd0);
        v0 = 2'b00;
        tick;
`endif

        // Out-of-range select on N_IN=3
        sel2 = 2'd3; v2 = 3'b111;
        #1;
        check("oor_listo", 32'(li2), 32'd0);
        repeat (3) tick;
        check("oor_valido", 32'(vo2), 32'd0);
        sel2 = 2'd2;
        #1;
        check("sel2_listo", 32'(li2), 32'b100);
        tick;
        check("sel2_salida", 32'(sal2), 32'h3333);
        check("sel2_canal", 32'(can2), 32'd2);
        v2 = 3'b000;

        // Round-robin, all channels valid
        v1 = 4'b1111;
        #1;
        check("rr_first_listo", 32'(li1), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("rr_all_canal", 32'(can1), 32'(i % 4));
            check("rr_all_salida", 32'(sal1), 32'hA000 + 32'(i % 4));
        end
        v1 = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("rr_23_canal", 32'(can1), (i % 2 == 0) ? 32'd2 : 32'd3);
        end
        v1 = 4'b0100;
        tick;
        check("rr_ch2_canal", 32'(can1), 32'd2);
        check("rr_ch2_valido", 32'(vo1), 32'd1);

        // Async reset mid-stream
        reset = 1'b1;
        #1;
        check("arst_valido", 32'(vo1), 32'd0);
        check("arst_salida", 32'(sal1), 32'd0);
        check("arst_canal", 32'(can1), 32'd0);
        check("arst_listo", 32'(li1), 32'd0);
        v1 = 4'b1001;
        @(negedge clk);
        reset = 1'b0;
        tick;
        check("arst_first_canal", 32'(can1), 32'd0);
        check("arst_first_salida", 32'(sal1), 32'hA000);
        tick;
        check("arst_next_canal", 32'(can1), 32'd3);
        v1 = 4'b0000;
        tick;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_multiplexor_nin_reg

`default_nettype wire

// File: doc/multiplexor_nin_reg.md
Name: multiplexor_nin_reg

Overview:
Registered N-input, 1-output data multiplexer with valid/ready handshake on every channel and on the output. It is the parametrised successor of the 2:1 datapath mux in the BIP datapath. It serves wider operand/bus selection, for example ACC/immediate/memory-data sources, and shared-port funnelling. Selection is either fixed by a Sel port or round-robin among requesting channels, chosen by parameter. Output is a single-entry register, so latency is 1 cycle.

Parameters:
WIDTH, 16, data width per channel in bits (>=1).
N_IN, 4, number of input channels (>=2).
MODE, 0, 0 = fixed select via Sel; 1 = round-robin arbitration (Sel ignored).
SEL_W, $clog2(N_IN), width of Sel/Canal; derived, not to be overridden.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
Datos  in  N_IN*WIDTH  packed channel data; channel i = Datos[i*WIDTH +: WIDTH].
Valido_in  in  N_IN  per-channel data valid.
Listo_in  out  N_IN  per-channel ready; handshake fires on channel i when Valido_in[i] && Listo_in[i].
Sel  in  SEL_W  channel select (MODE 0 only).
Salida  out  WIDTH  registered selected data.
Canal  out  SEL_W  index of the channel that produced Salida.
Valido_out  out  1  Salida/Canal valid.
Listo_out  in  1  downstream ready.

Behaviour:
- Reset (async, active-high): Valido_out=0, Salida=0, Canal=0, round-robin pointer=N_IN-1, so channel 0 has first priority after reset. Reset mid-transfer discards the held word. No handshake fires while reset is high, and Listo_in=0.
- load_en = !Valido_out || Listo_out. The register accepts a new word when empty or being drained in the same cycle. This gives full throughput: one word per cycle.
- MODE 0: Listo_in[Sel] = load_en; all other Listo_in = 0. If Sel >= N_IN, no channel is ready and nothing loads. Listo_in does not depend on Valido_in.
- MODE 1: the grant is the first i with Valido_in[i]=1, searching from pointer+1 upward with wrap modulo N_IN. Listo_in = onehot(grant) & {N_IN{load_en}}. No valid input means no grant and all Listo_in=0. The pointer updates to the granted index only on a fired handshake.
- On a fired handshake on channel g at edge k: Salida=Datos[g], Canal=g, Valido_out=1 from cycle k+1.
- Output drain without a new load: Valido_out drops to 0. Salida and Canal hold their last values.
- Simultaneous drain and load: the new word replaces the old in the same edge, with no bubble.
- Stall (Valido_out=1, Listo_out=0): Salida, Canal and Valido_out are stable, and all Listo_in=0.
- Data may change only on a handshake. An upstream channel must hold Datos and Valido_in until its ready.

Optional Feature:
Macro MUX_PARITY_EN.
- Defined: adds output port Paridad (1 bit), registered alongside Salida = even parity (XOR reduction) of the loaded word. Reset value 0.
- Undefined: the port and its logic are absent, and the behaviour is otherwise identical.

Decomposition:
- Package mux_pkg: MODE_FIXED=0 and MODE_RR=1 constants, and a clog2 helper function for tools lacking $clog2.
- Sub-module rr_arbiter (N_IN parameter; inputs req, pointer; output one-hot grant and encoded index). It is instantiated only under MODE 1, via a generate.
- Top holds the handshake logic, the output register, the pointer and the optional parity.

Test Plan:
- MODE 0, N_IN=2, WIDTH=16: Datos ch0=16'hCCCC, ch1=16'hFF00, both valid, Listo_out=1, Sel=0 then 1 -> Salida=CCCC/Canal=0 one cycle after, then FF00/Canal=1; Listo_in tracks Sel.
- Backpressure: Listo_out=0 for 5 cycles after a load of 16'h1234 -> Salida holds 1234, Valido_out=1, all Listo_in=0; on release, the next word loads in the drain cycle with no bubble.
- MODE 1, N_IN=4, all valid continuously -> Canal sequence 0,1,2,3,0 on back-to-back cycles; with only ch2 and ch3 valid -> 2,3,2,3.
- Sel=3 with N_IN=3 (SEL_W=2) -> all Listo_in=0, Valido_out stays 0.
- Async reset asserted mid-stream while Valido_out=1 -> Valido_out=0, Salida=0, Canal=0 immediately without a clock edge; after release, MODE 1 grants ch0 first.
- With MUX_PARITY_EN defined: load 16'h0001 -> Paridad=1; load 16'h0003 -> Paridad=0.
